// File: rtl/bus_arb_pkg.sv
// Shared helpers for the round-robin bus arbiter and its output buffer:
// width helpers, per-entry field order and the round-robin pointer advance.
package bus_arb_pkg;

    localparam int MAX_CH = 16;
    localparam int RR_W   = 4;

    // A single-channel build still carries a 1-bit channel field.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Entries are packed as {par (optional), ch, data}, data in the LSBs.
    function automatic int entry_width(input int data_w, input int ch_w, input bit par_en);
        return data_w + ch_w + (par_en ? 1 : 0);
    endfunction

    // Search restarts just past the channel that was last served.
    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] g, input int num_ch);
        if (int'(g) >= num_ch - 1) begin
            return '0;
        end
        return g + RR_W'(1);
    endfunction

endpackage

// File: rtl/bus_arb_fifo.sv
// First-word-fall-through buffer: head entry is visible whenever head_valid=1.
// Depth must be a power of two so the pointers wrap for free.
module bus_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic             is_full;
    logic             is_empty;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign do_push  = push_valid && !is_full;
    assign do_pop   = pop_ready && !is_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale words are never exposed because count gates them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Combinational read keeps the head visible with single-cycle push latency.
    assign head_valid = !is_empty;
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign full       = is_full;

endmodule

// File: rtl/bus_arb_pipe.sv
// Round-robin arbiter over NUM_CH valid/ready channels feeding a FWFT buffer.
// Define BUS_ARB_PIPE_PARITY_EN to store per-entry parity and expose out_par.
module bus_arb_pipe
    import bus_arb_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    localparam int CH_W  = ch_width(NUM_CH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
`ifdef BUS_ARB_PIPE_PARITY_EN
    output logic                    out_par,
`endif
    output logic [CNT_W-1:0]        fifo_count
);

`ifdef BUS_ARB_PIPE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int ENTRY_W = entry_width(WIDTH, CH_W, PAR_EN);

    typedef struct packed {
`ifdef BUS_ARB_PIPE_PARITY_EN
        logic            par;
`endif
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_found;
    logic             fifo_full;
    logic             push;
    logic [WIDTH-1:0] ch_data [NUM_CH];
    entry_t           push_entry;
    entry_t           head_entry;
    logic [ENTRY_W-1:0] head_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = push && (gnt_idx == CH_W'(gi));
        end
    endgenerate

    // Walk channels in order rr_ptr, rr_ptr+1, ... and take the first requester.
    always_comb begin
        logic [CH_W:0]   sum;
        logic [CH_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        idx       = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            sum = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
            if (sum >= (CH_W+1)'(NUM_CH)) begin
                sum = sum - (CH_W+1)'(NUM_CH);
            end
            idx = CH_W'(sum);
            if (!gnt_found && in_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // A pop in the same cycle does not open space for a push into a full buffer.
    assign push = gnt_found && !fifo_full && !reset;

    always_comb begin
        push_entry      = '0;
        push_entry.data = ch_data[gnt_idx];
        push_entry.ch   = gnt_idx;
`ifdef BUS_ARB_PIPE_PARITY_EN
        push_entry.par  = ^ch_data[gnt_idx];
`endif
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = CH_W'(rr_next(RR_W'(gnt_idx), NUM_CH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    bus_arb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srst       (reset),
        .push_valid (push),
        .push_data  (push_entry),
        .pop_ready  (out_ready),
        .head_valid (out_valid),
        .head_data  (head_bits),
        .count      (fifo_count),
        .full       (fifo_full)
    );

    assign head_entry = head_bits;
    assign out_data   = head_entry.data;
    assign out_ch     = head_entry.ch;
`ifdef BUS_ARB_PIPE_PARITY_EN
    assign out_par    = head_entry.par;
`endif

endmodule
